status_update: RTL and testbench

//  Lookup-resolve stage directly downstream of the status array in the I-cache pipeline.

---
 rtl/status_update_pkg.sv | 39 +++
 rtl/status_update_if.sv | 38 +++
 rtl/status_plru.sv | 57 +++++
 rtl/status_update.sv | 138 +++++++++++++
 tb/tb_status_update.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/status_update_pkg.sv
// status_update_pkg
// Shared constants and types for the I-cache status-row resolve stage.
// Contents: array geometry, row field offsets, the PLRU write mask,
// the FSM state encoding, the write-port record and the row-merge helper.
package status_update_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int ROW_WIDTH  = 8;
  localparam int NUM_BLOCKS = 8;
  localparam int NUM_WAYS   = 4;
  localparam int NUM_ROWS   = 2 ** ADDR_WIDTH;

  // Row layout: [3:0] per-way valid, [6:4] tree PLRU bits b0..b2, [7] spare.
  localparam int VALID_LSB = 0;
  localparam int PLRU_LSB  = 4;
  localparam int PLRU_BITS = 3;

  localparam logic [NUM_BLOCKS-1:0] PLRU_MASK = 8'h70;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_t;

  // One status-array write as driven on the write port.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ROW_WIDTH-1:0]  data;
    logic [NUM_BLOCKS-1:0] mask;
  } wr_t;

  // Apply a masked write on top of a row image.
  function automatic logic [ROW_WIDTH-1:0] merge_row(input logic [ROW_WIDTH-1:0] row,
                                                     input wr_t                  wr);
    return (row & ~wr.mask) | (wr.data & wr.mask);
  endfunction

endpackage

// File: rtl/status_update_if.sv
// status_update_if
// Bundles the lookup, fill, control, result and status-write signals of
// the resolve stage. The slave modport is the status_update side; the
// master modport is the pipeline / environment driving it.
interface status_update_if;
  import status_update_pkg::*;

  logic                  i_halt;
  logic                  i_flush;
  logic                  i_st_valid;
  logic [ROW_WIDTH-1:0]  i_st_data;
  logic [ADDR_WIDTH-1:0] i_st_set;
  logic [NUM_WAYS-1:0]   i_hit_way;
  logic                  i_fill_valid;
  logic [ADDR_WIDTH-1:0] i_fill_set;
  logic [1:0]            i_fill_way;
  logic                  o_valid;
  logic                  o_hit;
  logic [NUM_WAYS-1:0]   o_way;
  logic                  o_w_valid;
  logic [ADDR_WIDTH-1:0] o_w_addr;
  logic [ROW_WIDTH-1:0]  o_w_data;
  logic [NUM_BLOCKS-1:0] o_w_wmask;
  logic                  o_ready;

  modport master (
    output i_halt, i_flush, i_st_valid, i_st_data, i_st_set, i_hit_way,
           i_fill_valid, i_fill_set, i_fill_way,
    input  o_valid, o_hit, o_way, o_w_valid, o_w_addr, o_w_data, o_w_wmask, o_ready
  );

  modport slave (
    input  i_halt, i_flush, i_st_valid, i_st_data, i_st_set, i_hit_way,
           i_fill_valid, i_fill_set, i_fill_way,
    output o_valid, o_hit, o_way, o_w_valid, o_w_addr, o_w_data, o_w_wmask, o_ready
  );

endinterface

// File: rtl/status_plru.sv
// status_plru
// Combinational hit/victim resolution and 3-bit tree-PLRU touch for 4 ways.
// Ports: valid (per-way valid bits), plru (b0..b2), hit_way (tag matches)
//        -> hit, way (one-hot hit or victim way), plru_next (touched bits).
module status_plru
  import status_update_pkg::*;
(
  input  logic [NUM_WAYS-1:0]  valid,
  input  logic [PLRU_BITS-1:0] plru,
  input  logic [NUM_WAYS-1:0]  hit_way,
  output logic                 hit,
  output logic [NUM_WAYS-1:0]  way,
  output logic [PLRU_BITS-1:0] plru_next
);

  logic [NUM_WAYS-1:0] match;
  logic [1:0]          way_idx;

  // A tag match on an invalid way does not count as a hit.
  assign match = hit_way & valid;
  assign hit   = |match;

  always_comb begin
    way_idx = 2'd0;
    if (hit) begin
      // Descending scan so the lowest matching way wins if several match.
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
        if (match[i]) way_idx = 2'(i);
      end
    end else if (~&valid) begin
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
        if (!valid[i]) way_idx = 2'(i);
      end
    end else if (!plru[0]) begin
      way_idx = plru[1] ? 2'd1 : 2'd0;
    end else begin
      way_idx = plru[2] ? 2'd3 : 2'd2;
    end

    // Touch: point the tree bits away from the way just used.
    plru_next = plru;
    if (!way_idx[1]) begin
      plru_next[0] = 1'b1;
      plru_next[1] = (way_idx == 2'd0);
    end else begin
      plru_next[0] = 1'b0;
      plru_next[2] = (way_idx == 2'd2);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way_onehot
      assign way[gi] = (way_idx == 2'(gi));
    end
  endgenerate

endmodule

// File: rtl/status_update.sv
// status_update
// Lookup-resolve stage behind the I-cache status array. Resolves hit/miss
// from the registered status row and tag-hit vector, picks a victim, writes
// PLRU updates and refill valid bits back, and sweeps every row to zero
// after reset or flush.
// Ports: clk, arst_n (synchronous, active low), bus (status_update_if.slave:
//        halt/flush, lookup row + hit vector, refill, lookup result,
//        status write port, o_ready).
module status_update
  import status_update_pkg::*;
(
  input  logic           clk,
  input  logic           arst_n,
  status_update_if.slave bus
);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] count_reg, count_next;
  wr_t                   w_reg, w_next, hist_reg;
  logic                  valid_reg, hit_reg;
  logic [NUM_WAYS-1:0]   way_reg;

  logic                  run;
  logic                  lookup;
  logic [ROW_WIDTH-1:0]  row_old, row_fwd;
  logic                  hit;
  logic [NUM_WAYS-1:0]   way;
  logic [PLRU_BITS-1:0]  plru_next;
  logic [NUM_BLOCKS-1:0] fill_mask;
  logic                  unused_row_bits;

  assign run          = (state_reg == RUN);
  assign lookup       = bus.i_st_valid & run;
  assign bus.o_ready  = ~bus.i_halt & run;

  // The incoming row was read before the writes of the previous and the
  // current cycle landed; replay both (older first) when the set matches.
  assign row_old = (hist_reg.valid && hist_reg.addr == bus.i_st_set)
                   ? merge_row(bus.i_st_data, hist_reg) : bus.i_st_data;
  assign row_fwd = (w_reg.valid && w_reg.addr == bus.i_st_set)
                   ? merge_row(row_old, w_reg) : row_old;

  assign unused_row_bits = ^row_fwd[ROW_WIDTH-1:PLRU_LSB+PLRU_BITS];

  status_plru u_plru (
    .valid     (row_fwd[VALID_LSB +: NUM_WAYS]),
    .plru      (row_fwd[PLRU_LSB +: PLRU_BITS]),
    .hit_way   (bus.i_hit_way),
    .hit       (hit),
    .way       (way),
    .plru_next (plru_next)
  );

  // Refill touches only the valid bit of the filled way.
  generate
    for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_fill_mask
      if (gi >= VALID_LSB && gi < VALID_LSB + NUM_WAYS) begin : g_way_bit
        assign fill_mask[gi] = (bus.i_fill_way == 2'(gi - VALID_LSB));
      end else begin : g_other_bit
        assign fill_mask[gi] = 1'b0;
      end
    end
  endgenerate

  // Next state and write-port arbitration: sweep > fill > PLRU update.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    w_next     = '0;
    if (state_reg == SWEEP) begin
      w_next.valid = 1'b1;
      w_next.addr  = count_reg;
      w_next.data  = '0;
      w_next.mask  = '1;
      if (bus.i_flush) begin
        count_next = '0;
      end else if (count_reg == ADDR_WIDTH'(NUM_ROWS - 1)) begin
        state_next = RUN;
        count_next = '0;
      end else begin
        count_next = count_reg + ADDR_WIDTH'(1);
      end
    end else begin
      if (bus.i_flush) begin
        state_next = SWEEP;
        count_next = '0;
      end
      if (bus.i_fill_valid) begin
        w_next.valid = 1'b1;
        w_next.addr  = bus.i_fill_set;
        w_next.data  = fill_mask;
        w_next.mask  = fill_mask;
      end else if (lookup) begin
        w_next.valid = 1'b1;
        w_next.addr  = bus.i_st_set;
        w_next.data  = '0;
        w_next.data[PLRU_LSB +: PLRU_BITS] = plru_next;
        w_next.mask  = PLRU_MASK;
      end
    end
  end

  // Halt freezes everything, including the forward history.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_reg <= SWEEP;
      count_reg <= '0;
    end else if (!bus.i_halt) begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      w_reg     <= '0;
      hist_reg  <= '0;
      valid_reg <= 1'b0;
      hit_reg   <= 1'b0;
      way_reg   <= '0;
    end else if (!bus.i_halt) begin
      hist_reg  <= w_reg;
      w_reg     <= w_next;
      valid_reg <= lookup;
      hit_reg   <= lookup & hit;
      way_reg   <= lookup ? way : '0;
    end
  end

  assign bus.o_valid   = valid_reg;
  assign bus.o_hit     = hit_reg;
  assign bus.o_way     = way_reg;
  assign bus.o_w_valid = w_reg.valid;
  assign bus.o_w_addr  = w_reg.addr;
  assign bus.o_w_data  = w_reg.data;
  assign bus.o_w_wmask = w_reg.mask;

endmodule

// File: tb/tb_status_update.sv
// tb_status_update
// Directed bench for status_update: stimulus pushes expected lookup results
// and status writes into queues; a monitor pops and compares them whenever
// the DUT presents a result or a write after an unhalted clock edge.
module tb_status_update;
  import status_update_pkg::*;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  status_update_if bus();

  status_update dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  typedef struct {
    logic       hit;
    logic [3:0] way;
  } lk_exp_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] mask;
  } wr_exp_t;

  lk_exp_t lk_q[$];
  wr_exp_t wr_q[$];
  int      checks = 0;
  int      errors = 0;
  logic    edge_active = 1'b0;

  // Outputs only carry a new transaction after an edge that was neither
  // in reset nor halted.
  always @(posedge clk) edge_active <= arst_n & ~bus.i_halt;

  always @(negedge clk) begin
    if (edge_active) begin
      if (bus.o_valid) begin
        checks++;
        if (lk_q.size() == 0) begin
          errors++;
          $display("FAIL lookup_unexpected: got hit=%0b way=%b, required no result", bus.o_hit, bus.o_way);
        end else begin
          lk_exp_t e;
          e = lk_q.pop_front();
          if (bus.o_hit !== e.hit || bus.o_way !== e.way) begin
            errors++;
            $display("FAIL lookup: got hit=%0b way=%b, required hit=%0b way=%b", bus.o_hit, bus.o_way, e.hit, e.way);
          end else begin
            $display("lookup ok: hit=%0b way=%b", bus.o_hit, bus.o_way);
          end
        end
      end
      if (bus.o_w_valid) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr=%0d data=%h mask=%h, required no write", bus.o_w_addr, bus.o_w_data, bus.o_w_wmask);
        end else begin
          wr_exp_t w;
          w = wr_q.pop_front();
          if (bus.o_w_addr !== w.addr || bus.o_w_data !== w.data || bus.o_w_wmask !== w.mask) begin
            errors++;
            $display("FAIL write: got addr=%0d data=%h mask=%h, required addr=%0d data=%h mask=%h", bus.o_w_addr, bus.o_w_data, bus.o_w_wmask, w.addr, w.data, w.mask);
          end else begin
            $display("write ok: addr=%0d data=%h mask=%h", bus.o_w_addr, bus.o_w_data, bus.o_w_wmask);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_halt       = 1'b0;
    bus.i_flush      = 1'b0;
    bus.i_st_valid   = 1'b0;
    bus.i_st_data    = '0;
    bus.i_st_set     = '0;
    bus.i_hit_way    = '0;
    bus.i_fill_valid = 1'b0;
    bus.i_fill_set   = '0;
    bus.i_fill_way   = '0;
  endtask

  task automatic push_wr(input logic [3:0] addr, input logic [7:0] data, input logic [7:0] mask);
    wr_exp_t w;
    w.addr = addr;
    w.data = data;
    w.mask = mask;
    wr_q.push_back(w);
  endtask

  task automatic push_lk(input logic hit, input logic [3:0] way);
    lk_exp_t e;
    e.hit = hit;
    e.way = way;
    lk_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 16; i++) push_wr(4'(i), 8'h00, 8'hFF);
  endtask

  task automatic drive_lookup(input logic [3:0] set, input logic [7:0] row, input logic [3:0] hv);
    bus.i_st_valid = 1'b1;
    bus.i_st_set   = set;
    bus.i_st_data  = row;
    bus.i_hit_way  = hv;
  endtask

  task automatic drive_fill(input logic [3:0] set, input logic [1:0] fway);
    bus.i_fill_valid = 1'b1;
    bus.i_fill_set   = set;
    bus.i_fill_way   = fway;
  endtask

  // One lookup cycle that also produces a PLRU update write.
  task automatic lookup(input logic [3:0] set, input logic [7:0] row, input logic [3:0] hv,
                        input logic exp_hit, input logic [3:0] exp_way, input logic [7:0] exp_data);
    drive_lookup(set, row, hv);
    push_lk(exp_hit, exp_way);
    push_wr(set, exp_data, 8'h70);
    tick();
    clear_inputs();
  endtask

  task automatic fill(input logic [3:0] set, input logic [1:0] fway,
                      input logic [7:0] exp_bits);
    drive_fill(set, fway);
    push_wr(set, exp_bits, exp_bits);
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    arst_n = 1'b0;
    repeat (3) tick();
    check("reset_o_valid", 32'(bus.o_valid), 32'd0);
    check("reset_o_w_valid", 32'(bus.o_w_valid), 32'd0);
    check("reset_o_ready", 32'(bus.o_ready), 32'd0);

    // Post-reset sweep: 16 cycles not ready, rows 0..15 cleared.
    push_sweep();
    arst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sweep_ready_low_%0d", i), 32'(bus.o_ready), 32'd0);
      tick();
    end
    check("sweep_done_ready", 32'(bus.o_ready), 32'd1);

    // Miss on empty row -> way 0, PLRU 0x30.
    lookup(4'd3, 8'h00, 4'b0000, 1'b0, 4'b0001, 8'h30);
    // Fill way 0 then hit on way 0.
    fill(4'd3, 2'd0, 8'h01);
    lookup(4'd3, 8'h01, 4'b0001, 1'b1, 4'b0001, 8'h30);
    // Back-to-back on set 5: second row forwarded to 0x3F.
    lookup(4'd5, 8'h0F, 4'b0000, 1'b0, 4'b0001, 8'h30);
    lookup(4'd5, 8'h0F, 4'b0000, 1'b0, 4'b0100, 8'h60);
    // Fill and PLRU update collide: only the fill is written.
    drive_fill(4'd7, 2'd0);
    drive_lookup(4'd2, 8'h00, 4'b0000);
    push_lk(1'b0, 4'b0001);
    push_wr(4'd7, 8'h01, 8'h01);
    tick();
    clear_inputs();
    // Victim selection corners.
    lookup(4'd9,  8'h07, 4'b0000, 1'b0, 4'b1000, 8'h00);
    lookup(4'd10, 8'h1F, 4'b0100, 1'b1, 4'b0100, 8'h40);
    lookup(4'd11, 8'h5F, 4'b0000, 1'b0, 4'b1000, 8'h00);
    lookup(4'd12, 8'h0D, 4'b0010, 1'b0, 4'b0010, 8'h10);
    // Fill way 2 forwarded into the very next lookup.
    fill(4'd14, 2'd2, 8'h04);
    lookup(4'd14, 8'h00, 4'b0100, 1'b1, 4'b0100, 8'h40);
    // Older history entry forwarded across an unrelated fill.
    lookup(4'd6, 8'h0F, 4'b0000, 1'b0, 4'b0001, 8'h30);
    fill(4'd8, 2'd1, 8'h02);
    lookup(4'd6, 8'h0F, 4'b0000, 1'b0, 4'b0100, 8'h60);

    // Halt for 3 cycles with junk on the inputs: nothing may move.
    lookup(4'd13, 8'h00, 4'b0000, 1'b0, 4'b0001, 8'h30);
    bus.i_halt = 1'b1;
    drive_lookup(4'd13, 8'hFF, 4'b1111);
    drive_fill(4'd13, 2'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("halt_ready_%0d", i), 32'(bus.o_ready), 32'd0);
      check($sformatf("halt_o_valid_%0d", i), 32'(bus.o_valid), 32'd1);
      check($sformatf("halt_o_way_%0d", i), 32'(bus.o_way), 32'b0001);
      check($sformatf("halt_w_valid_%0d", i), 32'(bus.o_w_valid), 32'd1);
      check($sformatf("halt_w_addr_%0d", i), 32'(bus.o_w_addr), 32'd13);
      check($sformatf("halt_w_data_%0d", i), 32'(bus.o_w_data), 32'h30);
    end

    // Flush restarts the full sweep from row 0.
    clear_inputs();
    bus.i_flush = 1'b1;
    push_sweep();
    tick();
    clear_inputs();
    check("flush_ready_low", 32'(bus.o_ready), 32'd0);
    check("flush_o_valid", 32'(bus.o_valid), 32'd0);
    check("flush_w_valid", 32'(bus.o_w_valid), 32'd0);
    repeat (16) tick();
    check("flush_sweep_done_ready", 32'(bus.o_ready), 32'd1);
    repeat (2) tick();
    check("lookups_all_seen", 32'(lk_q.size()), 32'd0);
    check("writes_all_seen", 32'(wr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
